// File: rtl/cdf_accumulate.sv
// Reads a packed histogram word by word and streams its saturating running sum (CDF)
// to the store stage, one registered value per cycle.
module cdf_accumulate #(
  parameter int unsigned NUM_BINS      = 256,
  parameter int unsigned BIN_WIDTH     = 16,
  parameter int unsigned BINS_PER_WORD = 8,
  parameter int unsigned SUM_WIDTH     = 20,
  parameter logic [15:0] HIST_BASE     = 16'h0000,
  parameter logic [15:0] CDF_BASE      = 16'h0100
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               Start,
  input  logic [BIN_WIDTH*BINS_PER_WORD-1:0] ReadBus,
  output logic [15:0]                        ReadAddress,
  output logic                               ReadEnable,
  output logic                               StartOut,
  output logic [SUM_WIDTH-1:0]               ResultOut,
  output logic [15:0]                        StoreAddressOut,
  output logic                               Busy,
  output logic                               Done,
  output logic                               Overflow
);

  localparam int unsigned NumWords = NUM_BINS / BINS_PER_WORD;
  localparam int unsigned WordW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned BinW     = (BINS_PER_WORD > 1) ? $clog2(BINS_PER_WORD) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StEmit, StDone} state_e;

  state_e                             state_q, state_d;
  logic [WordW-1:0]                   word_q, word_d;
  logic [BinW-1:0]                    bin_q, bin_d;
  logic [SUM_WIDTH-1:0]               sum_q, sum_d;
  logic [BIN_WIDTH*BINS_PER_WORD-1:0] data_q, data_d;
  logic                               ovf_q, ovf_d;
  logic                               start_q, start_d;
  logic [SUM_WIDTH-1:0]               result_q, result_d;
  logic [15:0]                        addr_q, addr_d;
  logic                               done_q, done_d;

  logic [BIN_WIDTH-1:0] bin_val;
  logic [SUM_WIDTH:0]   sum_ext;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bin_d    = bin_q;
    sum_d    = sum_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    start_d  = 1'b0;
    result_d = '0;
    addr_d   = '0;
    done_d   = 1'b0;
    bin_val  = '0;
    sum_ext  = '0;

    case (state_q)
      StIdle: begin
        // A Start landing on the Done pulse is treated as arriving while busy.
        if (Start && !done_q) begin
          sum_d   = '0;
          word_d  = '0;
          bin_d   = '0;
          ovf_d   = 1'b0;
          state_d = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        data_d  = ReadBus;
        bin_d   = '0;
        state_d = StEmit;
      end
      StEmit: begin
        bin_val = data_q[BIN_WIDTH*int'(bin_q) +: BIN_WIDTH];
        sum_ext = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - BIN_WIDTH){1'b0}}, bin_val};
        if (sum_ext[SUM_WIDTH]) begin
          sum_d = '1;
          ovf_d = 1'b1;
        end else begin
          sum_d = sum_ext[SUM_WIDTH-1:0];
        end
        start_d  = 1'b1;
        result_d = sum_d;
        addr_d   = CDF_BASE + 16'(word_q) * 16'(BINS_PER_WORD) + 16'(bin_q);
        if (bin_q == BinW'(BINS_PER_WORD - 1)) begin
          if (word_q == WordW'(NumWords - 1)) begin
            state_d = StDone;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = StRead;
          end
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      word_q   <= '0;
      bin_q    <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bin_q    <= bin_d;
      sum_q    <= sum_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  assign ReadEnable      = (state_q == StRead);
  assign ReadAddress     = ReadEnable ? HIST_BASE + 16'(word_q) : 16'h0000;
  assign StartOut        = start_q;
  assign ResultOut       = result_q;
  assign StoreAddressOut = addr_q;
  assign Busy            = (state_q != StIdle);
  assign Done            = done_q;
  assign Overflow        = ovf_q;

endmodule

// File: tb/tb_cdf_accumulate.sv
// Randomised bench for cdf_accumulate: a histogram memory responder plus a running-sum
// reference computed directly from the bin values.
module tb_cdf_accumulate;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         Start = 1'b0;
  logic [127:0] ReadBus = '0;
  logic [15:0]  ReadAddress;
  logic         ReadEnable;
  logic         StartOut;
  logic [19:0]  ResultOut;
  logic [15:0]  StoreAddressOut;
  logic         Busy;
  logic         Done;
  logic         Overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned hist[256];
  int unsigned exp_val[256];
  int          first_clamp;
  logic        re_prev = 1'b0;
  logic [15:0] ra_prev = '0;

  always #5 clock = ~clock;

  cdf_accumulate dut (
    .clock          (clock),
    .reset          (reset),
    .Start          (Start),
    .ReadBus        (ReadBus),
    .ReadAddress    (ReadAddress),
    .ReadEnable     (ReadEnable),
    .StartOut       (StartOut),
    .ResultOut      (ResultOut),
    .StoreAddressOut(StoreAddressOut),
    .Busy           (Busy),
    .Done           (Done),
    .Overflow       (Overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_word(input logic [15:0] a);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (int'(a) * 8 + k < 256) w[16*k +: 16] = 16'(hist[int'(a) * 8 + k]);
    end
    return w;
  endfunction

  // Memory answers only in the cycle after the read strobe; garbage otherwise.
  always @(negedge clock) begin
    ReadBus = {$urandom, $urandom, $urandom, $urandom};
    if (re_prev) ReadBus = pack_word(ra_prev);
    re_prev = ReadEnable;
    ra_prev = ReadAddress;
  end

  task automatic fill(input int mode);
    int unsigned s;
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       hist[i] = 1;
        1:       hist[i] = (i == 0) ? 32'hFFFF : 32'h0;
        2:       hist[i] = 32'hFFFF;
        3:       hist[i] = $urandom_range(0, 3000);
        default: hist[i] = $urandom_range(0, 65535);
      endcase
    end
    s = 0;
    first_clamp = 256;
    for (int i = 0; i < 256; i++) begin
      s = s + hist[i];
      if (s > 32'hFFFFF) begin
        s = 32'hFFFFF;
        if (first_clamp == 256) first_clamp = i;
      end
      exp_val[i] = s;
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 Start = 1'b1;
    @(posedge clock); #1 Start = 1'b0;
  endtask

  task automatic run_pass(input int mode, input bit repulse);
    int n_out;
    int n_rd;
    bit ovf_exp;
    n_out   = 0;
    n_rd    = 0;
    ovf_exp = 1'b0;
    fill(mode);
    pulse_start();
    for (int c = 1; c <= 340; c++) begin
      Start = (repulse && (c == 50 || c == 200 || c == 322)) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (ReadEnable) begin
        check_eq("rd_addr", 32'(ReadAddress), 32'(n_rd));
        check_eq("rd_cycle", 32'(c), 32'(1 + 10 * n_rd));
        n_rd++;
      end
      if (StartOut) begin
        if (n_out < 256) begin
          if (n_out >= first_clamp) ovf_exp = 1'b1;
          check_eq("result", 32'(ResultOut), exp_val[n_out]);
          check_eq("st_addr", 32'(StoreAddressOut), 32'(256 + n_out));
          check_eq("out_cycle", 32'(c), 32'(4 + 10 * (n_out / 8) + n_out % 8));
        end
        n_out++;
      end else begin
        check_eq("idle_result", 32'(ResultOut), 32'h0);
        check_eq("idle_addr", 32'(StoreAddressOut), 32'h0);
      end
      check_eq("overflow", 32'(Overflow), 32'(ovf_exp));
      check_eq("busy", 32'(Busy), 32'(c < 322));
      check_eq("done", 32'(Done), 32'(c == 322));
      @(posedge clock); #1;
    end
    Start = 1'b0;
    check_eq("n_out", 32'(n_out), 32'd256);
    check_eq("n_rd", 32'(n_rd), 32'd32);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_startout"}, 32'(StartOut), 32'h0);
    check_eq({tag, "_result"}, 32'(ResultOut), 32'h0);
    check_eq({tag, "_staddr"}, 32'(StoreAddressOut), 32'h0);
    check_eq({tag, "_re"}, 32'(ReadEnable), 32'h0);
    check_eq({tag, "_raddr"}, 32'(ReadAddress), 32'h0);
    check_eq({tag, "_busy"}, 32'(Busy), 32'h0);
    check_eq({tag, "_done"}, 32'(Done), 32'h0);
    check_eq({tag, "_ovf"}, 32'(Overflow), 32'h0);
  endtask

  task automatic abort_pass();
    fill(2);
    pulse_start();
    repeat (100) @(posedge clock);
    #1;
    check_eq("pre_abort_busy", 32'(Busy), 32'h1);
    check_eq("pre_abort_ovf", 32'(Overflow), 32'h1);
    #2 reset = 1'b1;
    #1 check_all_zero("abort");
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("post_abort_startout", 32'(StartOut), 32'h0);
      check_eq("post_abort_busy", 32'(Busy), 32'h0);
    end
  endtask

  initial begin
    #1 check_all_zero("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    run_pass(0, 1'b0);
    run_pass(1, 1'b0);
    run_pass(2, 1'b0);
    run_pass(3, 1'b1);
    abort_pass();
    run_pass(0, 1'b0);
    run_pass(4, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
